// File: rtl/fp_addsub_wb_pkg.sv
// Shared types and helpers for the add/sub writeback stage.
//   o_err_t        : error codes produced by add_sub_top err_o
//   fflags_t       : RISC-V accrued exception flags {nv,dz,of,uf,nx}
//   err_to_fflags  : maps an err code to the flags it raises
//   CANON_NAN      : canonical quiet NaN at default widths
package fp_addsub_wb_pkg;

  localparam int unsigned DEF_SIG_BITS = 23;
  localparam int unsigned DEF_EXP_BITS = 8;

  typedef enum logic [2:0] {
    NONE      = 3'd0,
    OVERFLOW  = 3'd1,
    UNDERFLOW = 3'd2,
    INVALID   = 3'd3,
    INEXACT   = 3'd4
  } o_err_t;

  typedef struct packed {
    logic nv;
    logic dz;
    logic of;
    logic uf;
    logic nx;
  } fflags_t;

  localparam logic [DEF_SIG_BITS+DEF_EXP_BITS:0] CANON_NAN =
    {1'b0, {DEF_EXP_BITS{1'b1}}, 1'b1, {(DEF_SIG_BITS-1){1'b0}}};

  // Reserved codes (5-7) are treated as invalid.
  function automatic fflags_t err_to_fflags(input logic [2:0] err);
    fflags_t f;
    f = '0;
    case (err)
      NONE:      ;
      OVERFLOW:  begin f.of = 1'b1; f.nx = 1'b1; end
      UNDERFLOW: begin f.uf = 1'b1; f.nx = 1'b1; end
      INVALID:   f.nv = 1'b1;
      INEXACT:   f.nx = 1'b1;
      default:   f.nv = 1'b1;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/fp_addsub_wb_if.sv
// Handshake bundle between add_sub_top, the writeback stage and the FP
// register file.
//   upstream  : valid_i, ready_o, rd_i, fp_i, err_i
//   downstream: wb_valid_o, wb_ready_i, wb_rd_o, wb_data_o
// Modports: slave = writeback stage, master = its environment.
interface fp_addsub_wb_if #(
  parameter int unsigned RD_BITS = 5,
  parameter int unsigned FP_W    = 32
);

  logic               valid_i;
  logic               ready_o;
  logic [RD_BITS-1:0] rd_i;
  logic [FP_W-1:0]    fp_i;
  logic [2:0]         err_i;
  logic               wb_valid_o;
  logic               wb_ready_i;
  logic [RD_BITS-1:0] wb_rd_o;
  logic [FP_W-1:0]    wb_data_o;

  modport slave (
    input  valid_i, rd_i, fp_i, err_i, wb_ready_i,
    output ready_o, wb_valid_o, wb_rd_o, wb_data_o
  );

  modport master (
    output valid_i, rd_i, fp_i, err_i, wb_ready_i,
    input  ready_o, wb_valid_o, wb_rd_o, wb_data_o
  );

endinterface

// File: rtl/fp_addsub_wb_fifo.sv
// fp_wb_fifo: generic DEPTH x WIDTH FIFO with occupancy count.
//   i_clk, i_rst_n : clock, async active-low reset
//   i_push, i_data : write request (ignored when full)
//   i_pop          : read request (ignored when empty)
//   o_data         : head entry (undefined content when empty)
//   o_full/o_empty : derived from the registered count only
module fp_wb_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 2
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_data  = r_mem[r_rd_ptr];

  // Storage needs no reset: head is only meaningful while count != 0.
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/fp_addsub_wb.sv
// fp_addsub_wb: writeback stage after add_sub_top.
// Buffers {rd, fp, err} in a small FIFO, offers the head to the FP register
// file over valid/ready, accrues sticky fflags on each pop and counts retired
// results (saturating).
//   clk, rst_n    : clock, async active-low reset
//   bus (slave)   : valid_i/ready_o/rd_i/fp_i/err_i upstream,
//                   wb_valid_o/wb_ready_i/wb_rd_o/wb_data_o downstream
//   fflags_o      : sticky {NV,DZ,OF,UF,NX}
//   fflags_clr_i  : synchronous clear of fflags_o (a same-cycle pop still sets)
//   retired_o     : saturating popped-result count
// Build option: FP_WB_CANON_NAN_EN -- results whose err maps to NV are
// written back as the canonical quiet NaN.
module fp_addsub_wb
  import fp_addsub_wb_pkg::*;
#(
  parameter int unsigned SIG_BITS = DEF_SIG_BITS,
  parameter int unsigned EXP_BITS = DEF_EXP_BITS,
  parameter int unsigned RD_BITS  = 5,
  parameter int unsigned DEPTH    = 2,
  parameter int unsigned CNT_BITS = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  fp_addsub_wb_if.slave       bus,
  output logic [4:0]          fflags_o,
  input  logic                fflags_clr_i,
  output logic [CNT_BITS-1:0] retired_o
);

  localparam int unsigned FP_W  = SIG_BITS + EXP_BITS + 1;
  localparam int unsigned ENT_W = RD_BITS + FP_W + 3;

  logic [ENT_W-1:0]    w_head;
  logic                w_full;
  logic                w_empty;
  logic                w_push;
  logic                w_pop;
  logic [RD_BITS-1:0]  w_head_rd;
  logic [FP_W-1:0]     w_head_fp;
  logic [2:0]          w_head_err;
  logic [FP_W-1:0]     w_head_data;
  fflags_t             w_head_flags;

  logic [RD_BITS-1:0]  r_last_rd;
  logic [FP_W-1:0]     r_last_data;
  fflags_t             r_fflags;
  logic [CNT_BITS-1:0] r_retired;

  assign w_push = bus.valid_i && !w_full;
  assign w_pop  = !w_empty && bus.wb_ready_i;

  fp_wb_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_push  (w_push),
    .i_data  ({bus.rd_i, bus.fp_i, bus.err_i}),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign {w_head_rd, w_head_fp, w_head_err} = w_head;
  assign w_head_flags = err_to_fflags(w_head_err);

`ifdef FP_WB_CANON_NAN_EN
  localparam logic [FP_W-1:0] L_CANON_NAN =
    {1'b0, {EXP_BITS{1'b1}}, 1'b1, {(SIG_BITS-1){1'b0}}};
  assign w_head_data = w_head_flags.nv ? L_CANON_NAN : w_head_fp;
`else
  assign w_head_data = w_head_fp;
`endif

  // Outputs come from registered state only; when empty the last popped
  // values are presented instead of the stale FIFO slot.
  assign bus.ready_o    = !w_full;
  assign bus.wb_valid_o = !w_empty;
  assign bus.wb_rd_o    = w_empty ? r_last_rd   : w_head_rd;
  assign bus.wb_data_o  = w_empty ? r_last_data : w_head_data;
  assign fflags_o       = r_fflags;
  assign retired_o      = r_retired;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_rd   <= '0;
      r_last_data <= '0;
      r_fflags    <= '0;
      r_retired   <= '0;
    end else begin
      if (w_pop) begin
        r_last_rd   <= w_head_rd;
        r_last_data <= w_head_data;
      end
      r_fflags <= fflags_t'((fflags_clr_i ? '0 : r_fflags) |
                            (w_pop ? w_head_flags : '0));
      if (w_pop && (r_retired != '1)) r_retired <= r_retired + CNT_BITS'(1);
    end
  end

endmodule

// File: tb/tb_fp_addsub_wb.sv
module tb_fp_addsub_wb;

  localparam int unsigned RD_BITS = 5;
  localparam int unsigned FP_W    = 32;
  localparam int unsigned DEPTH   = 2;
  localparam int unsigned CNT_MAX = 65535;

  logic        clk;
  logic        rst_n;
  logic        fflags_clr_i;
  logic [4:0]  fflags_o;
  logic [15:0] retired_o;

  fp_addsub_wb_if #(.RD_BITS(RD_BITS), .FP_W(FP_W)) bus ();

  fp_addsub_wb #(
    .SIG_BITS (23),
    .EXP_BITS (8),
    .RD_BITS  (RD_BITS),
    .DEPTH    (DEPTH),
    .CNT_BITS (16)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus),
    .fflags_o     (fflags_o),
    .fflags_clr_i (fflags_clr_i),
    .retired_o    (retired_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: queue of pending results plus architectural state.
  typedef struct {
    logic [4:0]  rd;
    logic [31:0] fp;
    logic [2:0]  err;
  } ent_t;

  ent_t        q[$];
  logic [4:0]  m_flags;
  int unsigned m_ret;
  logic [4:0]  m_last_rd;
  logic [31:0] m_last_data;

  int unsigned n_vec;
  int unsigned n_err;

  function automatic logic [4:0] ref_flags(input logic [2:0] e);
    case (e)
      3'd0:    return 5'b00000;
      3'd1:    return 5'b00101;
      3'd2:    return 5'b00011;
      3'd3:    return 5'b10000;
      3'd4:    return 5'b00001;
      default: return 5'b10000;
    endcase
  endfunction

  function automatic logic [31:0] ref_data(input ent_t e);
`ifdef FP_WB_CANON_NAN_EN
    if (e.err == 3'd3 || e.err > 3'd4) return 32'h7FC0_0000;
`endif
    return e.fp;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_clear();
    q.delete();
    m_flags     = '0;
    m_ret       = 0;
    m_last_rd   = '0;
    m_last_data = '0;
  endtask

  task automatic chk_outputs();
    chk("ready", 64'(bus.ready_o), 64'(q.size() < DEPTH));
    chk("wb_valid", 64'(bus.wb_valid_o), 64'(q.size() > 0));
    if (q.size() > 0) begin
      chk("wb_rd", 64'(bus.wb_rd_o), 64'(q[0].rd));
      chk("wb_data", 64'(bus.wb_data_o), 64'(ref_data(q[0])));
    end else begin
      chk("wb_rd_hold", 64'(bus.wb_rd_o), 64'(m_last_rd));
      chk("wb_data_hold", 64'(bus.wb_data_o), 64'(m_last_data));
    end
    chk("fflags", 64'(fflags_o), 64'(m_flags));
    chk("retired", 64'(retired_o), 64'(m_ret));
  endtask

  // One clock cycle: drive at negedge, check, clock, update model.
  task automatic step(input bit v, input logic [4:0] rd, input logic [31:0] fp,
                      input logic [2:0] err, input bit wbr, input bit clr);
    bit   do_push;
    bit   do_pop;
    ent_t head;
    ent_t e;
    bus.valid_i    = v;
    bus.rd_i       = rd;
    bus.fp_i       = fp;
    bus.err_i      = err;
    bus.wb_ready_i = wbr;
    fflags_clr_i   = clr;
    #1;
    chk_outputs();
    do_push = v && (q.size() < DEPTH);
    do_pop  = wbr && (q.size() > 0);
    if (do_pop) head = q[0];
    @(posedge clk);
    m_flags = (clr ? 5'b0 : m_flags) | (do_pop ? ref_flags(head.err) : 5'b0);
    if (do_pop) begin
      void'(q.pop_front());
      m_last_rd   = head.rd;
      m_last_data = ref_data(head);
      if (m_ret < CNT_MAX) m_ret++;
    end
    if (do_push) begin
      e.rd = rd; e.fp = fp; e.err = err;
      q.push_back(e);
    end
    @(negedge clk);
  endtask

  task automatic idle(input bit wbr);
    step(1'b0, 5'd0, 32'd0, 3'd0, wbr, 1'b0);
  endtask

  task automatic do_reset();
    rst_n          = 1'b0;
    bus.valid_i    = 1'b0;
    bus.rd_i       = '0;
    bus.fp_i       = '0;
    bus.err_i      = '0;
    bus.wb_ready_i = 1'b0;
    fflags_clr_i   = 1'b0;
    model_clear();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    do_reset();

    // Reset values
    chk("rst_ready", 64'(bus.ready_o), 64'd1);
    chk("rst_wb_valid", 64'(bus.wb_valid_o), 64'd0);
    chk("rst_wb_rd", 64'(bus.wb_rd_o), 64'd0);
    chk("rst_wb_data", 64'(bus.wb_data_o), 64'd0);
    chk("rst_fflags", 64'(fflags_o), 64'd0);
    chk("rst_retired", 64'(retired_o), 64'd0);

    // Single push, visible the following cycle, then popped
    step(1'b1, 5'd3, 32'h4040_0000, 3'd0, 1'b1, 1'b0);
    chk("sp_valid", 64'(bus.wb_valid_o), 64'd1);
    chk("sp_rd", 64'(bus.wb_rd_o), 64'd3);
    chk("sp_data", 64'(bus.wb_data_o), 64'h4040_0000);
    idle(1'b1);
    chk("sp_retired", 64'(retired_o), 64'd1);
    chk("sp_fflags", 64'(fflags_o), 64'd0);
    chk("sp_hold_rd", 64'(bus.wb_rd_o), 64'd3);

    // Fill, ignored third push, ordered drain, ready rises after first pop
    step(1'b1, 5'd1, 32'h1111_1111, 3'd0, 1'b0, 1'b0);
    step(1'b1, 5'd2, 32'h2222_2222, 3'd0, 1'b0, 1'b0);
    chk("full_ready", 64'(bus.ready_o), 64'd0);
    step(1'b1, 5'd9, 32'h9999_9999, 3'd0, 1'b0, 1'b0);
    chk("full_ready2", 64'(bus.ready_o), 64'd0);
    chk("full_head", 64'(bus.wb_rd_o), 64'd1);
    idle(1'b1);
    chk("after_pop_ready", 64'(bus.ready_o), 64'd1);
    chk("order_rd2", 64'(bus.wb_rd_o), 64'd2);
    idle(1'b1);
    chk("drain_valid", 64'(bus.wb_valid_o), 64'd0);

    // Sticky flags and clear/pop collision
    step(1'b0, 5'd0, 32'd0, 3'd0, 1'b0, 1'b1);
    step(1'b1, 5'd4, 32'h7F80_0000, 3'd1, 1'b1, 1'b0);
    step(1'b1, 5'd5, 32'h0000_0001, 3'd2, 1'b1, 1'b0);
    chk("ff_of", 64'(fflags_o), 64'b00101);
    step(1'b1, 5'd6, 32'h7FC0_0001, 3'd3, 1'b1, 1'b0);
    chk("ff_of_uf", 64'(fflags_o), 64'b00111);
    step(1'b0, 5'd0, 32'd0, 3'd0, 1'b1, 1'b1);
    chk("ff_clr_pop", 64'(fflags_o), 64'b10000);

    // Invalid result data, with or without canonicalisation
    step(1'b1, 5'd7, 32'hFFC1_2345, 3'd3, 1'b0, 1'b1);
`ifdef FP_WB_CANON_NAN_EN
    chk("nan_data", 64'(bus.wb_data_o), 64'h7FC0_0000);
`else
    chk("nan_data", 64'(bus.wb_data_o), 64'hFFC1_2345);
`endif
    idle(1'b1);
    chk("nan_flags", 64'(fflags_o), 64'b10000);

    // Async reset while full with a pop being offered
    step(1'b1, 5'd10, 32'hAAAA_0000, 3'd1, 1'b0, 1'b0);
    step(1'b1, 5'd11, 32'hBBBB_0000, 3'd1, 1'b0, 1'b0);
    bus.wb_ready_i = 1'b1;
    bus.valid_i    = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_ready", 64'(bus.ready_o), 64'd1);
    chk("arst_wb_valid", 64'(bus.wb_valid_o), 64'd0);
    chk("arst_wb_rd", 64'(bus.wb_rd_o), 64'd0);
    chk("arst_wb_data", 64'(bus.wb_data_o), 64'd0);
    chk("arst_fflags", 64'(fflags_o), 64'd0);
    chk("arst_retired", 64'(retired_o), 64'd0);
    model_clear();
    @(posedge clk);
    @(negedge clk);
    chk("arst_no_pop", 64'(retired_o), 64'd0);
    rst_n = 1'b1;

    // Continuous push/pop: pointers wrap, ten pops retire
    for (int i = 0; i < 11; i++)
      step(1'b1, 5'(i + 12), 32'h3F80_0000 + 32'(i), 3'd0, 1'b1, 1'b0);
    chk("stream_retired", 64'(retired_o), 64'd10);

    // Randomised traffic
    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 31)), 32'($urandom()),
           3'($urandom_range(0, 7)), 1'($urandom_range(0, 2) != 0),
           1'($urandom_range(0, 15) == 0));
    repeat (3) idle(1'b1);

    // Counter saturation
    do_reset();
    for (int i = 0; i < 65540; i++)
      step(1'b1, 5'(i), 32'(i), 3'd0, 1'b1, 1'b0);
    chk("ret_sat", 64'(retired_o), 64'hFFFF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
